// File: rtl/counter_mod_updown_if.sv
// Control and status bundle for counter_mod_updown: step/load controls in,
// registered count, direction and terminal-count pulse out.
interface counter_mod_updown_if #(
  parameter int WIDTH = 6
);
  // No valid/ready handshake: every control is sampled at each rising clk
  // edge, and cnt/dir/tc are registered and change one clock after their inputs.
  logic             cnt_en;
  logic [1:0]       mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] cnt;
  logic             dir;
  logic             tc;

  modport master (
    output cnt_en, mode, load, load_val,
    input  cnt, dir, tc
  );

  modport slave (
    input  cnt_en, mode, load, load_val,
    output cnt, dir, tc
  );
endinterface

// File: rtl/counter_mod_updown.sv
// Bounded up/down/bounce/hold counter with clamped parallel load and a
// registered terminal-count pulse. Optional step prescaler: COUNTER_PRESCALE_EN.
module counter_mod_updown #(
  parameter int WIDTH    = 6,
  parameter int MIN_VAL  = 0,
  parameter int MAX_VAL  = 63,
  parameter int RST_VAL  = 1,
  parameter int PRESCALE = 4
) (
  input  logic                clk,
  input  logic                rst,
  counter_mod_updown_if.slave bus
);

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RST_VAL);
  // Degenerate range: a bounce "reversal" must not leave the single legal value.
  localparam logic [WIDTH-1:0] BNC_HI = (MIN_VAL == MAX_VAL) ? MIN_W : WIDTH'(MAX_VAL - 1);
  localparam logic [WIDTH-1:0] BNC_LO = (MIN_VAL == MAX_VAL) ? MIN_W : WIDTH'(MIN_VAL + 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] load_clamp;
  logic             do_step;

`ifdef COUNTER_PRESCALE_EN
  localparam int             PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  logic [PRE_W-1:0] pre_q, pre_d;
`endif

  always_comb begin
    load_clamp = bus.load_val;
    if (int'(bus.load_val) < MIN_VAL) begin
      load_clamp = MIN_W;
    end else if (int'(bus.load_val) > MAX_VAL) begin
      load_clamp = MAX_W;
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    tc_d    = 1'b0;
    do_step = 1'b0;
`ifdef COUNTER_PRESCALE_EN
    pre_d   = pre_q;
`endif

    if (bus.load) begin
      cnt_d = load_clamp;
      if (bus.mode == MODE_UP) begin
        dir_d = 1'b0;
      end else if (bus.mode == MODE_DOWN) begin
        dir_d = 1'b1;
      end
`ifdef COUNTER_PRESCALE_EN
      pre_d = '0;
`endif
    end else if (bus.cnt_en && (bus.mode != MODE_HOLD)) begin
`ifdef COUNTER_PRESCALE_EN
      if (pre_q == PRE_LAST) begin
        do_step = 1'b1;
        pre_d   = '0;
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
`else
      do_step = 1'b1;
`endif
    end

    if (do_step) begin
      case (bus.mode)
        MODE_UP: begin
          dir_d = 1'b0;
          if (cnt_q == MAX_W) begin
            cnt_d = MIN_W;
            tc_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end
        MODE_DOWN: begin
          dir_d = 1'b1;
          if (cnt_q == MIN_W) begin
            cnt_d = MAX_W;
            tc_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - WIDTH'(1);
          end
        end
        MODE_BOUNCE: begin
          if (!dir_q) begin
            if (cnt_q == MAX_W) begin
              cnt_d = BNC_HI;
              dir_d = 1'b1;
              tc_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + WIDTH'(1);
            end
          end else begin
            if (cnt_q == MIN_W) begin
              cnt_d = BNC_LO;
              dir_d = 1'b0;
              tc_d  = 1'b1;
            end else begin
              cnt_d = cnt_q - WIDTH'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= RST_W;
      dir_q <= 1'b0;
      tc_q  <= 1'b0;
`ifdef COUNTER_PRESCALE_EN
      pre_q <= '0;
`endif
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
      tc_q  <= tc_d;
`ifdef COUNTER_PRESCALE_EN
      pre_q <= pre_d;
`endif
    end
  end

  assign bus.cnt = cnt_q;
  assign bus.dir = dir_q;
  assign bus.tc  = tc_q;

endmodule
